// File: rtl/audio_rom_arbiter.sv
// Two-requester (CPU, AUX) read arbiter in front of a single-port audio ROM BRAM with registered output.
// Optional AUX read checksum, built only when AUDIO_ROM_ARB_CHKSUM_EN is defined.
module audio_rom_arbiter #(
  parameter int AW     = 14,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          aux_req,
  input  logic [AW-1:0] aux_addr,
  output logic          aux_ack,
  output logic [DW-1:0] aux_rdata,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout,
  output logic          busy
`ifdef AUDIO_ROM_ARB_CHKSUM_EN
  ,
  output logic [15:0]   aux_sum,
  input  logic          aux_sum_clr
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic {OWN_CPU, OWN_AUX} owner_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t        state_q;
  owner_t        owner_q;
  logic [2:0]    cnt_q;
  logic [AW-1:0] rom_addr_q;
  logic          cpu_ack_q;
  logic          aux_ack_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] aux_rdata_q;

  // A requester being acked this cycle sits out the next grant, so two
  // continuously-held requests alternate instead of the CPU hogging the ROM.
  logic cpu_elig;
  logic aux_elig;
  logic capture;

  assign cpu_elig = cpu_req & ~cpu_ack_q;
  assign aux_elig = aux_req & ~aux_ack_q;
  assign capture  = (state_q == S_WAIT) && (cnt_q == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      cnt_q       <= 3'd0;
      rom_addr_q  <= '0;
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      aux_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_elig) begin
            rom_addr_q <= cpu_addr;
            owner_q    <= OWN_CPU;
            cnt_q      <= LAT;
            state_q    <= S_WAIT;
          end else if (aux_elig) begin
            rom_addr_q <= aux_addr;
            owner_q    <= OWN_AUX;
            cnt_q      <= LAT;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            if (owner_q == OWN_CPU) begin
              cpu_rdata_q <= rom_dout;
              cpu_ack_q   <= 1'b1;
            end else begin
              aux_rdata_q <= rom_dout;
              aux_ack_q   <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef AUDIO_ROM_ARB_CHKSUM_EN
  logic [15:0] aux_sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aux_sum_q <= 16'h0000;
    end else if (aux_sum_clr) begin
      aux_sum_q <= 16'h0000;
    end else if (capture && (owner_q == OWN_AUX)) begin
      aux_sum_q <= aux_sum_q + 16'(rom_dout);
    end
  end

  assign aux_sum = aux_sum_q;
`endif

  assign rom_addr  = rom_addr_q;
  assign cpu_ack   = cpu_ack_q;
  assign aux_ack   = aux_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign aux_rdata = aux_rdata_q;
  assign busy      = (state_q == S_WAIT);

endmodule
